// File: rtl/ariane_axi.sv
// rtl/ariane_axi.sv - ariane_axi channel and bundle types (64-bit addr/data, 4-bit id)
package ariane_axi;

   localparam int unsigned AddrWidth = 64;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned IdWidth   = 4;
   localparam int unsigned UserWidth = 1;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [5:0]           atop;
      logic [UserWidth-1:0] user;
   } aw_chan_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic [StrbWidth-1:0] strb;
      logic                 last;
      logic [UserWidth-1:0] user;
   } w_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [1:0]           resp;
      logic [UserWidth-1:0] user;
   } b_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic                 lock;
      logic [3:0]           cache;
      logic [2:0]           prot;
      logic [3:0]           qos;
      logic [3:0]           region;
      logic [UserWidth-1:0] user;
   } ar_chan_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [DataWidth-1:0] data;
      logic [1:0]           resp;
      logic                 last;
      logic [UserWidth-1:0] user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;

endpackage

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 slave turning one burst at a time into single-beat SRAM accesses
module axi_sram_slave #(
   parameter logic [63:0] BaseAddr     = 64'h8000_0000,
   parameter logic [63:0] MemBytes     = 64'h0010_0000,
   parameter int unsigned MemAddrWidth = 17
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  ariane_axi::req_t                 axi_req_i,
   output ariane_axi::resp_t                axi_resp_o,
   output logic                             mem_req_o,
   output logic                             mem_we_o,
   output logic [MemAddrWidth-1:0]          mem_addr_o,
   output logic [ariane_axi::DataWidth-1:0] mem_wdata_o,
   output logic [ariane_axi::StrbWidth-1:0] mem_be_o,
   input  logic [ariane_axi::DataWidth-1:0] mem_rdata_i
);

   localparam int unsigned OffLsb = $clog2(ariane_axi::StrbWidth);
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;
   localparam logic [1:0] RespDecErr = 2'b11;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;
   localparam logic [1:0] BurstRsvd  = 2'b11;

   typedef enum logic [2:0] {IDLE, R_REQ, R_WAIT, R_VALID, W_DATA, W_RESP} state_e;
   state_e state_q, state_d;

   logic [ariane_axi::IdWidth-1:0]   id_q, id_d;
   logic [ariane_axi::AddrWidth-1:0] addr_q, addr_d;
   logic [7:0]                       len_q, len_d, beat_q, beat_d;
   logic [2:0]                       size_q, size_d;
   logic [1:0]                       burst_q, burst_d, err_q, err_d, rresp_q, rresp_d;
   logic [ariane_axi::DataWidth-1:0] rdata_q, rdata_d;
   logic                             prio_w_q, prio_w_d;

   logic [63:0] offset, step, container, lower, next_addr;
   logic [1:0]  w_err;
   logic        in_window, last_beat, rsvd_burst, beat_ok, ar_grant, aw_grant;
   logic        unused_bits;

   assign unused_bits = ^{axi_req_i, offset};

   // Per-beat window check and next beat address; arithmetic wraps at 2^64.
   always_comb begin
      offset     = addr_q - BaseAddr;
      in_window  = (addr_q >= BaseAddr) && (offset < MemBytes);
      rsvd_burst = (burst_q == BurstRsvd);
      beat_ok    = in_window && !rsvd_burst;
      last_beat  = (beat_q == len_q);
      step       = 64'd1 << size_q;
      container  = ({56'd0, len_q} + 64'd1) << size_q;
      lower      = addr_q & ~(container - 64'd1);
      next_addr  = addr_q;
      if (burst_q == BurstIncr) begin
         next_addr = addr_q + step;
      end else if (burst_q == BurstWrap) begin
         next_addr = addr_q + step;
         if (next_addr == lower + container) next_addr = lower;
      end
   end

   // When both sides request, the side not served last wins.
   assign ar_grant = axi_req_i.ar_valid && (!axi_req_i.aw_valid || !prio_w_q);
   assign aw_grant = axi_req_i.aw_valid && (!axi_req_i.ar_valid || prio_w_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ar_grant)      state_d = R_REQ;
                  else if (aw_grant) state_d = W_DATA;
         R_REQ:   state_d = beat_ok ? R_WAIT : R_VALID;
         R_WAIT:  state_d = R_VALID;
         R_VALID: if (axi_req_i.r_ready) state_d = last_beat ? IDLE : R_REQ;
         W_DATA:  if (axi_req_i.w_valid && last_beat) state_d = W_RESP;
         W_RESP:  if (axi_req_i.b_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      id_d     = id_q;
      addr_d   = addr_q;
      len_d    = len_q;
      size_d   = size_q;
      burst_d  = burst_q;
      beat_d   = beat_q;
      err_d    = err_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      prio_w_d = prio_w_q;
      w_err    = RespOkay;
      unique case (state_q)
         IDLE: begin
            if (ar_grant) begin
               {id_d, addr_d, len_d} = {axi_req_i.ar.id, axi_req_i.ar.addr, axi_req_i.ar.len};
               {size_d, burst_d}     = {axi_req_i.ar.size, axi_req_i.ar.burst};
               beat_d   = '0;
               prio_w_d = 1'b1;
            end else if (aw_grant) begin
               {id_d, addr_d, len_d} = {axi_req_i.aw.id, axi_req_i.aw.addr, axi_req_i.aw.len};
               {size_d, burst_d}     = {axi_req_i.aw.size, axi_req_i.aw.burst};
               beat_d   = '0;
               err_d    = RespOkay;
               prio_w_d = 1'b0;
            end
         end
         R_REQ: begin
            if (!beat_ok) begin
               rdata_d = '0;
               rresp_d = rsvd_burst ? RespSlvErr : RespDecErr;
            end
         end
         R_WAIT: begin
            rdata_d = mem_rdata_i;
            rresp_d = RespOkay;
         end
         R_VALID: begin
            if (axi_req_i.r_ready && !last_beat) begin
               addr_d = next_addr;
               beat_d = beat_q + 8'd1;
            end
         end
         W_DATA: begin
            if (axi_req_i.w_valid) begin
               if (rsvd_burst)      w_err = RespSlvErr;
               else if (!in_window) w_err = RespDecErr;
               if ((axi_req_i.w.last != last_beat) && (w_err == RespOkay)) w_err = RespSlvErr;
               // OKAY < SLVERR < DECERR numerically, so max keeps the worst seen
               if (w_err > err_q) err_d = w_err;
               if (!last_beat) begin
                  addr_d = next_addr;
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         beat_q   <= '0;
         err_q    <= RespOkay;
         rresp_q  <= RespOkay;
         rdata_q  <= '0;
         prio_w_q <= 1'b0;
      end else begin
         id_q     <= id_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         size_q   <= size_d;
         burst_q  <= burst_d;
         beat_q   <= beat_d;
         err_q    <= err_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
         prio_w_q <= prio_w_d;
      end
   end

   always_comb begin
      axi_resp_o  = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = offset[OffLsb +: MemAddrWidth];
      mem_wdata_o = axi_req_i.w.data;
      mem_be_o    = axi_req_i.w.strb;
      unique case (state_q)
         IDLE: begin
            axi_resp_o.ar_ready = ar_grant;
            axi_resp_o.aw_ready = aw_grant;
         end
         R_REQ: mem_req_o = beat_ok;
         R_VALID: begin
            axi_resp_o.r_valid = 1'b1;
            axi_resp_o.r.id    = id_q;
            axi_resp_o.r.data  = rdata_q;
            axi_resp_o.r.resp  = rresp_q;
            axi_resp_o.r.last  = last_beat;
         end
         W_DATA: begin
            axi_resp_o.w_ready = 1'b1;
            mem_req_o          = axi_req_i.w_valid && beat_ok;
            mem_we_o           = axi_req_i.w_valid && beat_ok;
         end
         W_RESP: begin
            axi_resp_o.b_valid = 1'b1;
            axi_resp_o.b.id    = id_q;
            axi_resp_o.b.resp  = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized bench checking axi_sram_slave against a burst-level model
module tb_axi_sram_slave;

   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam logic [63:0] BYTES = 64'h0010_0000;
   localparam int AW    = 17;
   localparam int WORDS = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   ariane_axi::req_t  req;
   ariane_axi::resp_t resp;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [63:0]   mem_wdata;
   logic [63:0]   mem_rdata = '0;
   logic [7:0]    mem_be;

   axi_sram_slave #(.BaseAddr(BASE), .MemBytes(BYTES), .MemAddrWidth(AW)) dut (
      .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_resp_o(resp),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata));

   always #5 clk = ~clk;

   typedef struct { logic we; logic [AW-1:0] addr; logic [63:0] data; logic [7:0] be; } strobe_t;

   logic [63:0] sram    [WORDS];
   logic [63:0] ref_mem [WORDS];
   strobe_t     strobes [$];
   int vec_cnt = 0;
   int err_cnt = 0;

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // SRAM with one-cycle read latency
   always @(posedge clk) begin
      if (mem_req) begin
         if (mem_we) sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_be);
         else        mem_rdata <= sram[mem_addr];
      end
   end

   always @(negedge clk) begin
      #3;
      if (mem_req) strobes.push_back('{mem_we, mem_addr, mem_wdata, mem_be});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle;
      @(negedge clk);
      #1;
   endtask

   function automatic logic [63:0] beat_addr(input logic [63:0] a, input int len, input int size,
                                             input logic [1:0] burst, input int i);
      logic [63:0] step, cont, lower;
      step = 64'd1 << size;
      case (burst)
         2'b00: return a;
         2'b10: begin
            cont  = step * 64'(len + 1);
            lower = a - (a % cont);
            return lower + (((a - lower) + step * 64'(i)) % cont);
         end
         default: return a + step * 64'(i);
      endcase
   endfunction

   function automatic bit in_win(input logic [63:0] a);
      return (a >= BASE) && (a < BASE + BYTES);
   endfunction

   function automatic logic [AW-1:0] word_of(input logic [63:0] a);
      logic [63:0] w;
      w = (a - BASE) >> 3;
      return w[AW-1:0];
   endfunction

   task automatic check_strobes(input string tag, input strobe_t exp_s[$]);
      check_eq({tag, "_strobe_cnt"}, strobes.size(), exp_s.size());
      for (int i = 0; i < exp_s.size() && i < strobes.size(); i++) begin
         check_eq({tag, "_strobe_we"}, strobes[i].we, exp_s[i].we);
         check_eq({tag, "_strobe_addr"}, strobes[i].addr, exp_s[i].addr);
         if (exp_s[i].we) begin
            check_eq({tag, "_strobe_data"}, strobes[i].data, exp_s[i].data);
            check_eq({tag, "_strobe_be"}, strobes[i].be, exp_s[i].be);
         end
      end
   endtask

   // stall < 0 picks a random r_ready hold-off per beat
   task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input int len, input int size,
                          input logic [1:0] burst, input int stall);
      logic [63:0] a, exp_data, held;
      logic [1:0]  exp_resp;
      int          lat, k, exp_lat, hold;
      strobe_t     s, exp_s[$];
      req.ar.id = id; req.ar.addr = addr; req.ar.len = 8'(len);
      req.ar.size = 3'(size); req.ar.burst = burst;
      req.ar_valid = 1'b1; req.r_ready = 1'b0;
      #1;
      k = 0;
      while (!resp.ar_ready && k < 40) begin next_cycle(); k++; end
      check_eq("ar_ready", resp.ar_ready, 1);
      strobes.delete();
      next_cycle();
      req.ar_valid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         a = beat_addr(addr, len, size, burst, i);
         if (burst != 2'b11 && in_win(a)) begin
            s.we = 1'b0; s.addr = word_of(a); s.data = '0; s.be = '0;
            exp_s.push_back(s);
            exp_data = ref_mem[word_of(a)]; exp_resp = 2'b00; exp_lat = 3;
         end else begin
            exp_data = '0; exp_resp = (burst == 2'b11) ? 2'b10 : 2'b11; exp_lat = 2;
         end
         #1;
         lat = 1;
         while (!resp.r_valid && lat < 10) begin next_cycle(); #1; lat++; end
         check_eq("r_latency", lat, exp_lat);
         held = resp.r.data;
         hold = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
         for (int c = 0; c < hold; c++) begin
            next_cycle(); #1;
            check_eq("r_stall_valid", resp.r_valid, 1);
            check_eq("r_stall_data", resp.r.data, held);
            check_eq("r_stall_no_req", mem_req, 0);
         end
         req.r_ready = 1'b1;
         #1;
         check_eq("r_data", resp.r.data, exp_data);
         check_eq("r_resp", resp.r.resp, exp_resp);
         check_eq("r_id", resp.r.id, id);
         check_eq("r_last", resp.r.last, (i == len));
         next_cycle();
         req.r_ready = 1'b0;
      end
      check_strobes("rd", exp_s);
   endtask

   // dmode 1: data = beat+1 with full strobes; last_early: w.last on beat 0 only
   task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input int len, input int size,
                           input logic [1:0] burst, input int dmode, input bit last_early);
      logic [63:0] a, d;
      logic [7:0]  be;
      logic [1:0]  exp_resp;
      bit          any_dec, any_slv, lst;
      int          k;
      strobe_t     s, exp_s[$];
      req.aw.id = id; req.aw.addr = addr; req.aw.len = 8'(len);
      req.aw.size = 3'(size); req.aw.burst = burst;
      req.aw_valid = 1'b1; req.w_valid = 1'b0; req.b_ready = 1'b0;
      #1;
      k = 0;
      while (!resp.aw_ready && k < 40) begin next_cycle(); k++; end
      check_eq("aw_ready", resp.aw_ready, 1);
      strobes.delete();
      next_cycle();
      req.aw_valid = 1'b0;
      any_dec = 1'b0;
      any_slv = (burst == 2'b11);
      for (int i = 0; i <= len; i++) begin
         k = int'($urandom_range(0, 2));
         for (int g = 0; g < k; g++) next_cycle();
         a   = beat_addr(addr, len, size, burst, i);
         d   = (dmode == 1) ? 64'(i + 1) : {$urandom, $urandom};
         be  = (dmode == 1) ? 8'hFF : 8'($urandom);
         lst = last_early ? (i == 0) : (i == len);
         if (lst != (i == len)) any_slv = 1'b1;
         req.w.data = d; req.w.strb = be; req.w.last = lst; req.w_valid = 1'b1;
         #1;
         check_eq("w_ready", resp.w_ready, 1);
         if (burst != 2'b11) begin
            if (in_win(a)) begin
               s.we = 1'b1; s.addr = word_of(a); s.data = d; s.be = be;
               exp_s.push_back(s);
               ref_mem[word_of(a)] = merge(ref_mem[word_of(a)], d, be);
            end else begin
               any_dec = 1'b1;
            end
         end
         next_cycle();
         req.w_valid = 1'b0;
      end
      exp_resp = any_dec ? 2'b11 : (any_slv ? 2'b10 : 2'b00);
      #1;
      k = 0;
      while (!resp.b_valid && k < 10) begin next_cycle(); #1; k++; end
      check_eq("b_valid", resp.b_valid, 1);
      k = int'($urandom_range(0, 2));
      for (int c = 0; c < k; c++) next_cycle();
      #1;
      check_eq("b_id", resp.b.id, id);
      check_eq("b_resp", resp.b.resp, exp_resp);
      req.b_ready = 1'b1;
      next_cycle();
      req.b_ready = 1'b0;
      check_strobes("wr", exp_s);
   endtask

   initial begin
      int          k, len, size;
      logic [1:0]  burst;
      logic [63:0] addr, step;
      req = '0;
      for (int i = 0; i < WORDS; i++) begin
         sram[i]    = {32'(i) * 32'h9E37_79B9, ~32'(i)};
         ref_mem[i] = {32'(i) * 32'h9E37_79B9, ~32'(i)};
      end
      sram[2]    = 64'hDEAD_BEEF;
      ref_mem[2] = 64'hDEAD_BEEF;

      repeat (3) next_cycle();
      check_eq("rst_ar_ready", resp.ar_ready, 0);
      check_eq("rst_r_valid", resp.r_valid, 0);
      check_eq("rst_b_valid", resp.b_valid, 0);
      check_eq("rst_w_ready", resp.w_ready, 0);
      check_eq("rst_mem_req", mem_req, 0);
      rst = 1'b0;
      next_cycle();

      // both channels requesting: read first, then write, then the pending read
      req.ar.id = 4'd5; req.ar.addr = BASE + 64'h10; req.ar.len = 8'd0;
      req.ar.size = 3'd3; req.ar.burst = 2'b01; req.ar_valid = 1'b1;
      req.aw.id = 4'd3; req.aw.addr = BASE; req.aw.len = 8'd3;
      req.aw.size = 3'd3; req.aw.burst = 2'b01; req.aw_valid = 1'b1;
      #1;
      check_eq("arb_first_ar", resp.ar_ready, 1);
      check_eq("arb_first_aw", resp.aw_ready, 0);
      do_read(4'd5, BASE + 64'h10, 0, 3, 2'b01, 5);
      req.ar.id = 4'd6; req.ar.addr = BASE; req.ar.len = 8'd3;
      req.ar.size = 3'd3; req.ar.burst = 2'b01; req.ar_valid = 1'b1;
      #1;
      check_eq("arb_rr_aw", resp.aw_ready, 1);
      check_eq("arb_rr_ar", resp.ar_ready, 0);
      do_write(4'd3, BASE, 3, 3, 2'b01, 1, 1'b0);
      do_read(4'd6, BASE, 3, 3, 2'b01, 0);

      do_read(4'd1, BASE + 64'h18, 3, 3, 2'b10, -1);
      do_read(4'd2, 64'h7FFF_FFF8, 0, 3, 2'b01, -1);
      do_write(4'd4, BASE + BYTES, 1, 3, 2'b01, 0, 1'b0);
      do_write(4'd8, BASE + BYTES - 64'd16, 3, 3, 2'b01, 0, 1'b0);
      do_read(4'd9, BASE + BYTES - 64'd16, 3, 3, 2'b01, -1);
      do_write(4'd10, BASE + 64'h40, 1, 3, 2'b01, 0, 1'b1);
      do_read(4'd10, BASE + 64'h40, 1, 3, 2'b01, -1);
      do_write(4'd11, BASE + 64'h80, 1, 3, 2'b11, 0, 1'b0);
      do_read(4'd11, BASE + 64'h80, 1, 3, 2'b11, -1);

      // reset in the middle of a read burst
      req.ar.id = 4'd7; req.ar.addr = BASE; req.ar.len = 8'd3;
      req.ar.size = 3'd3; req.ar.burst = 2'b01; req.ar_valid = 1'b1;
      #1;
      k = 0;
      while (!resp.ar_ready && k < 20) begin next_cycle(); k++; end
      next_cycle();
      req.ar_valid = 1'b0;
      #1;
      k = 0;
      while (!resp.r_valid && k < 10) begin next_cycle(); #1; k++; end
      check_eq("mid_rst_pre_rvalid", resp.r_valid, 1);
      rst = 1'b1;
      next_cycle();
      #1;
      check_eq("mid_rst_r_valid", resp.r_valid, 0);
      check_eq("mid_rst_r_data", resp.r.data, 0);
      check_eq("mid_rst_mem_req", mem_req, 0);
      rst = 1'b0;
      do_read(4'd12, BASE + 64'h8, 1, 3, 2'b01, -1);

      for (int it = 0; it < 40; it++) begin
         size  = int'($urandom_range(0, 3));
         step  = 64'd1 << size;
         burst = 2'($urandom_range(0, 2));
         if (burst == 2'b10) len = (1 << $urandom_range(1, 4)) - 1;
         else                len = int'($urandom_range(0, 7));
         if ($urandom_range(0, 5) == 0) addr = BASE + BYTES - 64'd32;
         else addr = (BASE + 64'($urandom_range(0, 511))) & ~(step - 64'd1);
         if ($urandom_range(0, 1) == 1)
            do_write(4'($urandom), addr, len, size, burst, 0, ($urandom_range(0, 7) == 0) && (len > 0));
         else
            do_read(4'($urandom), addr, len, size, burst, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- Testbench AXI4 slave that consumes the ariane_axi req_t/resp_t bundle driven by the core or crossbar.
- Translates each read/write burst into single-beat accesses on a simple SRAM port with 1-cycle read latency.
- Handles one transaction at a time with a read/write arbiter, burst address generation (FIXED/INCR/WRAP) and decode/protocol error responses.

Parameters:
- BaseAddr, 64'h8000_0000, first byte address served.
- MemBytes, 64'h0010_0000, size of the served window in bytes (power of two, multiple of StrbWidth).
- MemAddrWidth, 17, word-address width of the SRAM port (= log2(MemBytes/StrbWidth)).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- axi_req_i  in  $bits(ariane_axi::req_t)  AXI request bundle.
- axi_resp_o  out  $bits(ariane_axi::resp_t)  AXI response bundle.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  MemAddrWidth  word address = (beat_addr - BaseAddr) >> log2(StrbWidth).
- mem_wdata_o  out  ariane_axi::DataWidth  write data (= w.data).
- mem_be_o  out  ariane_axi::StrbWidth  byte enables (= w.strb).
- mem_rdata_i  in  ariane_axi::DataWidth  read data, valid the cycle after a read strobe.

Behaviour:
- Reset: state IDLE, all valid/ready outputs 0, mem_req_o 0, r/b payload 0, grant pointer = read. Reset mid-burst abandons the transaction silently; outputs are 0 the cycle after rst_i is sampled.
- States: IDLE, R_REQ, R_WAIT, R_VALID, W_DATA, W_RESP.
- IDLE: ar_ready = ar_valid & read-granted; aw_ready = aw_valid & write-granted.
- Arbitration: if only one of ar_valid/aw_valid is set, that one wins. If both are set, the side opposite the last-served side wins (round robin). The pointer updates on each accepted AR/AW.
- On AR handshake: latch id, addr, len, size, burst; beat counter = 0; go to R_REQ.
- On AW handshake: latch the same fields; beat counter = 0; error accumulator = OKAY; go to W_DATA.
- R_REQ:
  - Beat address in window: mem_req_o = 1, mem_we_o = 0; go to R_WAIT.
  - Otherwise (or burst = 2'b11): no strobe; r.data = 0; r.resp = DECERR (SLVERR for reserved burst); go directly to R_VALID.
- R_WAIT: latch mem_rdata_i into r.data, r.resp = OKAY; go to R_VALID.
- R_VALID:
  - r_valid = 1; r.id = latched id; r.last = (beat == len); r.user = 0.
  - Payload is held stable until r_ready.
  - On handshake: if last, go to IDLE; else advance address, beat++, go to R_REQ.
- Read latency: AR handshake in cycle t gives first r_valid in cycle t+3. Each later beat appears 3 cycles after the previous R handshake; out-of-window beats take 2.
- W_DATA:
  - w_ready = 1.
  - On W handshake with the beat in window: mem_req_o = mem_we_o = 1 in the same cycle (combinational from w_valid).
  - Out-of-window beat: data is dropped, accumulator = DECERR.
  - Reserved burst: accumulator = SLVERR and no strobes.
  - w.last != (beat == len) on any beat: accumulator = SLVERR (errors never downgrade).
  - Transaction ends on beat == len regardless of w.last; go to W_RESP. Otherwise advance address, beat++.
- W_RESP: b_valid = 1, b.id = latched id, b.resp = accumulator, b.user = 0; on b_ready go to IDLE.
- Address advance (step = 1 << size):
  - FIXED: unchanged.
  - INCR: addr + step.
  - WRAP: container = (len+1)*step with lower = addr & ~(container-1); next = addr + step, and if next == lower + container then next = lower.
  - Arithmetic is AddrWidth wide and wraps modulo 2^AddrWidth.
- The window check is done per beat, so a burst crossing the window top returns OKAY then DECERR beats.
- Unused channel ready signals are 0 outside their states. At most one mem_req_o per cycle. No outstanding transactions overlap.

Test Plan:
- Read: AR addr 0x8000_0010, len 0, size 3, INCR, id 5; SRAM word 2 = 0xDEAD_BEEF -> mem_addr_o = 2 strobed at t+1; r_valid at t+3 with data 0xDEAD_BEEF, id 5, OKAY, last 1.
- Write burst: AW 0x8000_0000, len 3, size 3, INCR, data 1..4, strb 0xFF -> writes to words 0,1,2,3; one B with OKAY. Readback burst returns 1,2,3,4 with last only on beat 3.
- WRAP: AR 0x8000_0018, len 3, size 3 -> mem_addr_o sequence 3,0,1,2.
- Out-of-window read at 0x7FFF_FFF8 -> no mem_req_o; r.data 0, DECERR. Out-of-window write -> B DECERR and no strobes.
- Arbitration/backpressure: ar_valid and aw_valid both high from reset -> read served first, then write; r_ready held low 5 cycles -> r payload stable and no new mem_req_o.
- Protocol error: len 1 write with w.last = 1 on beat 0 -> both beats written, B resp SLVERR. Reset asserted mid read burst -> r_valid 0 next cycle, state IDLE.
